// File: rtl/rr_burst_stream_arbiter.sv
// Round-robin arbiter with bounded sticky bursts, sharing one registered,
// source-tagged valid/ready output stage between n_req valid/ready producers.
module rr_burst_stream_arbiter #(
  parameter int width     = 8,
  parameter int n_req     = 2,
  parameter int max_burst = 4,
  localparam int idw      = (n_req > 1) ? $clog2(n_req) : 1,
  localparam int bcw      = $clog2(max_burst + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [idw-1:0]         out_id
);

  // Handshake: a beat moves on any edge where valid and ready are both high.
  // Producers hold valid/data until ready; req_ready may depend on req_valid,
  // and out_valid/out_data/out_id are held while out_valid && !out_ready.

  localparam logic [bcw-1:0] burst_max = bcw'(max_burst);
  localparam logic [idw-1:0] last_id   = idw'(n_req - 1);

  logic [idw-1:0]   owner;
  logic [bcw-1:0]   burst_cnt;
  logic [idw-1:0]   sel;
  logic             sel_found;
  logic             sticky;
  logic             can_accept;
  logic             xfer;
  logic [width-1:0] sel_data;

  function automatic logic [idw-1:0] rot_idx(input logic [idw-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= n_req) sum = sum - n_req;
    return idw'(sum);
  endfunction

  assign can_accept = !out_valid || out_ready;

  // burst_cnt == 0 only after reset: no burst is running, so the scan starts
  // at owner+1 and requester 0 is served first.
  assign sticky = req_valid[owner] && (burst_cnt != '0) && (burst_cnt < burst_max);

  // Owner is checked last in the scan, so a lone requester keeps streaming
  // after its burst limit and simply restarts its burst.
  always_comb begin
    sel       = owner;
    sel_found = 1'b0;
    if (sticky) begin
      sel_found = 1'b1;
    end else begin
      for (int k = 1; k <= n_req; k++) begin
        if (!sel_found && req_valid[rot_idx(owner, k)]) begin
          sel       = rot_idx(owner, k);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign xfer = can_accept && sel_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[sel] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < n_req; i++) begin
      if (idw'(i) == sel) sel_data = req_data[i*width +: width];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      owner     <= last_id;
      burst_cnt <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= sel;
      if (sticky) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        owner     <= sel;
        burst_cnt <= bcw'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

  stall_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_id));

endmodule

// File: tb/tb_rr_burst_stream_arbiter.sv
// Randomised and directed bench for rr_burst_stream_arbiter: a reference model
// predicts every accepted beat into a queue that a separate monitor drains.
module tb_rr_burst_stream_arbiter;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int MB  = 4;
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data  = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;

  rr_burst_stream_arbiter #(.width(W), .n_req(N), .max_burst(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int               vpct[N];
  int               rpct = 100;
  logic [W-1:0]     src_q[N][$];
  logic [IDW+W-1:0] exp_q[$];
  int               obs_id[$];
  int               m_owner = N - 1;
  int               m_cnt = 0;
  bit               m_ov = 1'b0;
  logic [N-1:0]     granted = '0;
  int               wait_cnt[N];
  int               n_cmp = 0;
  int               n_err = 0;
  int               pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Arbitration rule in its plain form: keep the owner while its burst runs,
  // otherwise the first valid requester after the owner, owner itself last.
  function automatic int pick(input logic [N-1:0] v, input int own, input int cnt);
    if (cnt > 0 && cnt < MB && v[own]) return own;
    for (int k = 1; k <= N; k++) if (v[(own + k) % N]) return (own + k) % N;
    return -1;
  endfunction

  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !granted[i])) begin
          if (src_q[i].size() > 0 && $urandom_range(99) < 32'(vpct[i])) begin
            req_valid[i]        = 1'b1;
            req_data[i*W +: W]  = src_q[i][0];
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      out_ready = ($urandom_range(99) < 32'(rpct));
    end
  end

  always @(negedge clk) begin : model_blk
    int           s;
    logic [N-1:0] er;
    bit           can;
    check("out_valid", out_valid, m_ov);
    if (rst) begin
      m_owner = N - 1;
      m_cnt   = 0;
      m_ov    = 1'b0;
      granted = '0;
      exp_q.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      can     = !m_ov || out_ready;
      s       = pick(req_valid, m_owner, m_cnt);
      er      = '0;
      granted = '0;
      if (can && s >= 0) er[s] = 1'b1;
      check("req_ready", req_ready, er);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i]) begin
            check("starve_wait_over_bound", wait_cnt[i] > (N - 1) * MB, 0);
            wait_cnt[i] = 0;
          end else if (|(req_valid & req_ready)) begin
            wait_cnt[i]++;
          end
        end else begin
          wait_cnt[i] = 0;
        end
      end
      if (can && s >= 0) begin
        if (src_q[s].size() > 0) begin
          exp_q.push_back({IDW'(s), src_q[s][0]});
          src_q[s].pop_front();
        end
        granted[s] = 1'b1;
        if (s == m_owner && m_cnt < MB) begin
          m_cnt++;
        end else begin
          m_owner = s;
          m_cnt   = 1;
        end
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor_blk
    logic [IDW+W-1:0] e;
    if (!rst && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q[0];
        check("out_id", out_id, e[W +: IDW]);
        check("out_data", out_data, e[W-1:0]);
        if (out_ready) begin
          obs_id.push_back(int'(e[W +: IDW]));
          exp_q.pop_front();
          pop_cnt++;
        end
      end
    end
  end

  task automatic load_rand(input int i, input int n);
    for (int k = 0; k < n; k++) src_q[i].push_back(W'($urandom_range(255)));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    bit busy;
    n = 0;
    forever begin
      busy = (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) busy = 1'b1;
      if (!busy || n >= 3000) break;
      @(posedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, n >= 3000, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin : main
    int pc0;
    int t5_exp[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < N; i++) vpct[i] = 100;
    rpct = 100;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // both requesters always valid: bursts of four alternate, req0 first
    obs_id.delete();
    @(posedge clk);
    for (int i = 0; i < N; i++) load_rand(i, 16);
    drain("burst4");
    check("t2_count", obs_id.size(), 32);
    for (int k = 0; k < 12; k++)
      check("t2_id_seq", (k < obs_id.size()) ? obs_id[k] : -1, (k / 4) % 2);

    // lone requester streams past its burst limit with no idle cycle
    @(posedge clk);
    for (int k = 0; k < 6; k++) src_q[1].push_back(W'(8'h11 + k));
    pc0 = pop_cnt;
    repeat (7) @(negedge clk);
    #1;
    check("t3_back_to_back", pop_cnt - pc0, 6);
    drain("t3");

    // downstream stall of five cycles with both requesters pending
    @(posedge clk);
    for (int i = 0; i < N; i++) load_rand(i, 8);
    repeat (3) @(posedge clk);
    rpct = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("t4_stall_ready", req_ready, 0);
      check("t4_stall_valid", out_valid, 1);
    end
    rpct = 100;
    drain("t4");

    // req0 runs dry after two beats, req1 takes over and keeps a full burst
    do_reset(2);
    obs_id.delete();
    @(posedge clk);
    load_rand(0, 2);
    load_rand(1, 8);
    repeat (3) @(posedge clk);
    load_rand(0, 6);
    drain("t5");
    for (int k = 0; k < 10; k++)
      check("t5_id_seq", (k < obs_id.size()) ? obs_id[k] : -1, t5_exp[k]);

    // reset while a beat sits in the output register
    @(posedge clk);
    for (int i = 0; i < N; i++) load_rand(i, 8);
    repeat (3) @(posedge clk);
    check("t6_valid_before_rst", out_valid, 1);
    do_reset(1);
    @(negedge clk);
    #1;
    check("t6_out_valid_after_rst", out_valid, 0);
    check("t6_first_grant", req_ready, 2'b01);
    drain("t6");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        vpct[i] = int'($urandom_range(100, 30));
        load_rand(i, 40);
      end
      rpct = int'($urandom_range(90, 40));
      drain("rand");
    end
    rpct = 100;

    check("final_exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_err++;
    $display("FAIL watchdog: actual=timeout required=finish at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
